// File: rtl/lcd_driver.sv
// lcd_driver: timing engine for a character LCD bus.
// Each accepted byte is played out as SETUP -> PULSE -> HOLD -> WAIT on the
// lcd_data/lcd_ctrl/lcd_enable pins. Firmware polls busy.
// Optional feature: define LCD_DRIVER_FIFO_EN to put a 4-entry FIFO in front
// of the FSM. Without it, exactly one byte is in flight and wr_ready is high
// only in IDLE.
module lcd_driver #(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 2,
    parameter int EXEC_CYCLES  = 10,
    parameter int CLEAR_CYCLES = 100,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic [1:0] lcd_ctrl,
    output logic       lcd_enable
);
    // Handshake: the byte {wr_rs, wr_data} transfers on a rising clk edge where
    // wr_valid && wr_ready. Once wr_valid is raised, the source holds wr_valid,
    // wr_rs and wr_data stable until that edge; wr_ready never depends on wr_valid.

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

    // Counter load values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             byte_avail;  // a byte is ready to start SETUP
    logic [8:0]       byte_head;   // {rs, data} of that byte
    logic             byte_take;   // FSM consumes byte_head this edge
    logic             queued;      // bytes waiting in front of the FSM
    logic             is_clear;    // current byte needs the long execution wait

`ifdef LCD_DRIVER_FIFO_EN
    logic [8:0] fifo_mem [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] count;
    logic       push;

    assign push       = wr_valid && wr_ready;
    assign wr_ready   = (count != 3'd4);
    assign byte_avail = (count != 3'd0);
    assign byte_head  = fifo_mem[rd_ptr];
    assign queued     = byte_avail;

    // FIFO pointers and occupancy; a push and a pop on one edge cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (byte_take)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, byte_take})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; entries are only read after being written, so no reset.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {wr_rs, wr_data};
    end
`else
    // The output registers themselves hold the single in-flight byte.
    assign wr_ready   = (state == IDLE);
    assign byte_avail = wr_valid && wr_ready;
    assign byte_head  = {wr_rs, wr_data};
    assign queued     = 1'b0;
`endif

    assign is_clear = !lcd_ctrl[1] &&
                      (lcd_data == 8'h01 || lcd_data == 8'h02 || lcd_data == 8'h03);

    assign busy = (state != IDLE) || queued;

    // Next-state and counter reload; the counter is loaded on every state entry.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        byte_take  = 1'b0;
        case (state)
            IDLE: begin
                if (byte_avail) begin
                    state_next = SETUP;
                    cnt_next   = SETUP_LD;
                    byte_take  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_next = PULSE;
                    cnt_next   = PULSE_LD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_next = WAIT;
                    cnt_next   = is_clear ? CLEAR_LD : EXEC_LD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    if (byte_avail) begin
                        state_next = SETUP;
                        cnt_next   = SETUP_LD;
                        byte_take  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and registered LCD pins; data/ctrl change only when a byte is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            lcd_enable <= 1'b0;
            lcd_data   <= 8'h00;
            lcd_ctrl   <= 2'b00;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            lcd_enable <= (state_next == PULSE);
            if (byte_take) begin
                lcd_data <= byte_head[7:0];
                lcd_ctrl <= {byte_head[8], 1'b0};
            end
        end
    end

endmodule
